axi_addr_remap_arbiter: RTL and testbench

Two-requester AXI address-channel arbiter with per-requester address remapping, placed between the X-HEEP/loader AXI masters and the single PS slave port. It grants the AW and AR channels independently, round-robin, and holds each grant until that transaction's response completes. It adds a fixed per-requester offset to the granted address and routes W/R/B handshakes to and from the current owner. Data and ID buses are broadcast or muxed combinationally; only the handshakes are sequenced.

---
 rtl/axi_remap_pkg.sv | 22 ++
 rtl/axi_remap_channel_fsm.sv | 100 ++++++++++
 rtl/axi_addr_remap_arbiter.sv | 125 ++++++++++++
 tb/tb_axi_addr_remap_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_remap_pkg.sv
// Shared types and helpers for the two-requester AXI address remap arbiter.
// One channel FSM state enum is used by both the write and read paths.
package axi_remap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } chan_state_e;

  localparam logic [31:0] DEFAULT_OFFSET = 32'h4000_0000;

  // Round-robin pick: on a tie the requester that did not win last time goes first.
  function automatic logic pick_grant(input logic [1:0] req, input logic last_grant);
    if (req[0] && req[1]) begin
      return ~last_grant;
    end
    return req[1];
  endfunction

endpackage

// File: rtl/axi_remap_channel_fsm.sv
// One AXI address channel: round-robin grant, per-requester offset add and
// address handshake sequencing; data/response routing is done by the parent.
module axi_remap_channel_fsm
  import axi_remap_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  OFFSET_0 = ADDR_W'(DEFAULT_OFFSET),
  parameter logic [ADDR_W-1:0]  OFFSET_1 = ADDR_W'(DEFAULT_OFFSET),
  parameter bit                 HAS_DATA = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            s_avalid_i,
  input  logic [2*ADDR_W-1:0]   s_addr_i,
  output logic [1:0]            s_aready_o,
  output logic                  m_avalid_o,
  input  logic                  m_aready_i,
  output logic [ADDR_W-1:0]     m_addr_o,
  input  logic                  data_done_i,
  input  logic                  resp_done_i,
  output logic                  owner_o,
  output chan_state_e           state_o
);

  chan_state_e       state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              avalid_q, avalid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    avalid_d     = avalid_q;
    addr_d       = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|s_avalid_i) begin
          owner_d  = pick_grant(s_avalid_i, last_grant_q);
          addr_d   = owner_d ? (s_addr_i[2*ADDR_W-1:ADDR_W] + OFFSET_1)
                             : (s_addr_i[ADDR_W-1:0] + OFFSET_0);
          avalid_d = 1'b1;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_aready_i) begin
          avalid_d = 1'b0;
          state_d  = HAS_DATA ? ST_DATA : ST_RESP;
        end
      end
      ST_DATA: begin
        if (data_done_i) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_done_i) begin
          last_grant_d = owner_q;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        avalid_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      avalid_q     <= 1'b0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      avalid_q     <= avalid_d;
      addr_q       <= addr_d;
    end
  end

  always_comb begin
    s_aready_o = 2'b00;
    if (state_q == ST_ADDR) begin
      s_aready_o[owner_q] = m_aready_i;
    end
  end

  assign m_avalid_o = avalid_q;
  assign m_addr_o   = addr_q;
  assign owner_o    = owner_q;
  assign state_o    = state_q;

endmodule

// File: rtl/axi_addr_remap_arbiter.sv
// Two-requester AXI arbiter with independent AW/AR grants and per-requester
// address offsets; W/B/R handshakes are routed to the current owner only.
module axi_addr_remap_arbiter
  import axi_remap_pkg::*;
#(
  parameter int unsigned                AXI_ADDR_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0]  OFFSET_0       = AXI_ADDR_WIDTH'(DEFAULT_OFFSET),
  parameter logic [AXI_ADDR_WIDTH-1:0]  OFFSET_1       = AXI_ADDR_WIDTH'(DEFAULT_OFFSET)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [1:0]                    s_awvalid_in,
  output logic [1:0]                    s_awready_out,
  input  logic [2*AXI_ADDR_WIDTH-1:0]   s_awaddr_in,
  input  logic [1:0]                    s_wvalid_in,
  input  logic [1:0]                    s_wlast_in,
  output logic [1:0]                    s_wready_out,
  output logic [1:0]                    s_bvalid_out,
  input  logic [1:0]                    s_bready_in,
  input  logic [1:0]                    s_arvalid_in,
  output logic [1:0]                    s_arready_out,
  input  logic [2*AXI_ADDR_WIDTH-1:0]   s_araddr_in,
  output logic [1:0]                    s_rvalid_out,
  input  logic [1:0]                    s_rready_in,
  output logic                          m_awvalid_out,
  input  logic                          m_awready_in,
  output logic [AXI_ADDR_WIDTH-1:0]     m_awaddr_out,
  output logic                          m_wvalid_out,
  output logic                          m_wlast_out,
  input  logic                          m_wready_in,
  input  logic                          m_bvalid_in,
  output logic                          m_bready_out,
  output logic                          m_arvalid_out,
  input  logic                          m_arready_in,
  output logic [AXI_ADDR_WIDTH-1:0]     m_araddr_out,
  input  logic                          m_rvalid_in,
  input  logic                          m_rlast_in,
  output logic                          m_rready_out,
  output logic                          wr_owner_out,
  output logic                          rd_owner_out
);

  chan_state_e wr_state;
  chan_state_e rd_state;
  logic        wr_owner;
  logic        rd_owner;
  logic        wr_data_done;
  logic        wr_resp_done;
  logic        rd_resp_done;

  axi_remap_channel_fsm #(
    .ADDR_W   (AXI_ADDR_WIDTH),
    .OFFSET_0 (OFFSET_0),
    .OFFSET_1 (OFFSET_1),
    .HAS_DATA (1'b1)
  ) u_wr_fsm (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .s_avalid_i  (s_awvalid_in),
    .s_addr_i    (s_awaddr_in),
    .s_aready_o  (s_awready_out),
    .m_avalid_o  (m_awvalid_out),
    .m_aready_i  (m_awready_in),
    .m_addr_o    (m_awaddr_out),
    .data_done_i (wr_data_done),
    .resp_done_i (wr_resp_done),
    .owner_o     (wr_owner),
    .state_o     (wr_state)
  );

  axi_remap_channel_fsm #(
    .ADDR_W   (AXI_ADDR_WIDTH),
    .OFFSET_0 (OFFSET_0),
    .OFFSET_1 (OFFSET_1),
    .HAS_DATA (1'b0)
  ) u_rd_fsm (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .s_avalid_i  (s_arvalid_in),
    .s_addr_i    (s_araddr_in),
    .s_aready_o  (s_arready_out),
    .m_avalid_o  (m_arvalid_out),
    .m_aready_i  (m_arready_in),
    .m_addr_o    (m_araddr_out),
    .data_done_i (1'b0),
    .resp_done_i (rd_resp_done),
    .owner_o     (rd_owner),
    .state_o     (rd_state)
  );

  // The non-owner always sees valid/ready low, so it can never complete a beat.
  always_comb begin
    m_wvalid_out = 1'b0;
    m_wlast_out  = 1'b0;
    s_wready_out = 2'b00;
    m_bready_out = 1'b0;
    s_bvalid_out = 2'b00;
    if (wr_state == ST_DATA) begin
      m_wvalid_out           = s_wvalid_in[wr_owner];
      m_wlast_out            = s_wlast_in[wr_owner];
      s_wready_out[wr_owner] = m_wready_in;
    end
    if (wr_state == ST_RESP) begin
      m_bready_out           = s_bready_in[wr_owner];
      s_bvalid_out[wr_owner] = m_bvalid_in;
    end
  end

  always_comb begin
    m_rready_out = 1'b0;
    s_rvalid_out = 2'b00;
    if (rd_state == ST_RESP) begin
      m_rready_out           = s_rready_in[rd_owner];
      s_rvalid_out[rd_owner] = m_rvalid_in;
    end
  end

  assign wr_data_done = m_wvalid_out & m_wready_in & m_wlast_out;
  assign wr_resp_done = m_bvalid_in & m_bready_out;
  assign rd_resp_done = m_rvalid_in & m_rready_out & m_rlast_in;

  assign wr_owner_out = wr_owner;
  assign rd_owner_out = rd_owner;

endmodule

// File: tb/tb_axi_addr_remap_arbiter.sv
// Self-checking bench for axi_addr_remap_arbiter: hand-written corner sequences
// plus a table of remap/round-robin vectors checked through a scoreboard queue.
module tb_axi_addr_remap_arbiter;

  localparam int W = 32;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [1:0]     s_awvalid_in, s_awready_out;
  logic [2*W-1:0] s_awaddr_in;
  logic [1:0]     s_wvalid_in, s_wlast_in, s_wready_out;
  logic [1:0]     s_bvalid_out, s_bready_in;
  logic [1:0]     s_arvalid_in, s_arready_out;
  logic [2*W-1:0] s_araddr_in;
  logic [1:0]     s_rvalid_out, s_rready_in;
  logic           m_awvalid_out, m_awready_in;
  logic [W-1:0]   m_awaddr_out;
  logic           m_wvalid_out, m_wlast_out, m_wready_in;
  logic           m_bvalid_in, m_bready_out;
  logic           m_arvalid_out, m_arready_in;
  logic [W-1:0]   m_araddr_out;
  logic           m_rvalid_in, m_rlast_in, m_rready_out;
  logic           wr_owner_out, rd_owner_out;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    bit          is_rd;
    logic        owner;
    logic [31:0] addr;
  } exp_t;

  typedef struct {
    bit          is_rd;
    logic [1:0]  req;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        exp_owner;
    logic [31:0] exp_addr;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];

  axi_addr_remap_arbiter #(
    .AXI_ADDR_WIDTH (W),
    .OFFSET_0       (32'h4000_0000),
    .OFFSET_1       (32'h4000_0000)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .s_awvalid_in  (s_awvalid_in),
    .s_awready_out (s_awready_out),
    .s_awaddr_in   (s_awaddr_in),
    .s_wvalid_in   (s_wvalid_in),
    .s_wlast_in    (s_wlast_in),
    .s_wready_out  (s_wready_out),
    .s_bvalid_out  (s_bvalid_out),
    .s_bready_in   (s_bready_in),
    .s_arvalid_in  (s_arvalid_in),
    .s_arready_out (s_arready_out),
    .s_araddr_in   (s_araddr_in),
    .s_rvalid_out  (s_rvalid_out),
    .s_rready_in   (s_rready_in),
    .m_awvalid_out (m_awvalid_out),
    .m_awready_in  (m_awready_in),
    .m_awaddr_out  (m_awaddr_out),
    .m_wvalid_out  (m_wvalid_out),
    .m_wlast_out   (m_wlast_out),
    .m_wready_in   (m_wready_in),
    .m_bvalid_in   (m_bvalid_in),
    .m_bready_out  (m_bready_out),
    .m_arvalid_out (m_arvalid_out),
    .m_arready_in  (m_arready_in),
    .m_araddr_out  (m_araddr_out),
    .m_rvalid_in   (m_rvalid_in),
    .m_rlast_in    (m_rlast_in),
    .m_rready_out  (m_rready_out),
    .wr_owner_out  (wr_owner_out),
    .rd_owner_out  (rd_owner_out)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

  task automatic clearInputs();
    s_awvalid_in = '0; s_awaddr_in = '0; s_wvalid_in = '0; s_wlast_in = '0;
    s_bready_in  = '0; s_arvalid_in = '0; s_araddr_in = '0; s_rready_in = '0;
    m_awready_in = 1'b0; m_wready_in = 1'b0; m_bvalid_in = 1'b0;
    m_arready_in = 1'b0; m_rvalid_in = 1'b0; m_rlast_in = 1'b0;
  endtask

  // Readies are driven high during reset to prove they are gated off.
  task automatic doReset();
    clearInputs();
    s_awvalid_in = 2'b11; s_arvalid_in = 2'b11;
    m_awready_in = 1'b1;  m_arready_in = 1'b1; m_wready_in = 1'b1;
    rst_i = 1'b1;
    tick();
    tick();
    #1;
    checkOutput("rst_valids", {m_awvalid_out, m_wvalid_out, m_arvalid_out}, 3'b000);
    checkOutput("rst_readies", {s_awready_out, s_wready_out, s_arready_out}, 6'b0);
    checkOutput("rst_awaddr", m_awaddr_out, 32'h0);
    checkOutput("rst_araddr", m_araddr_out, 32'h0);
    checkOutput("rst_owners", {wr_owner_out, rd_owner_out}, 2'b00);
    clearInputs();
    rst_i = 1'b0;
  endtask

  task automatic waitGrant(input bit is_rd);
    int   cycles;
    logic vld;
    exp_t e;
    cycles = 0;
    do begin
      tick();
      #1;
      cycles++;
      vld = is_rd ? m_arvalid_out : m_awvalid_out;
    end while (!vld && cycles < 8);
    checkOutput(is_rd ? "ar_grant_valid" : "aw_grant_valid", vld, 1'b1);
    checkOutput(is_rd ? "ar_grant_latency" : "aw_grant_latency", cycles, 1);
    if (sb.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL sb_underflow: got empty queue, expected a pending grant");
    end else begin
      e = sb.pop_front();
      checkOutput(e.is_rd ? "ar_addr" : "aw_addr", e.is_rd ? m_araddr_out : m_awaddr_out, e.addr);
      checkOutput(e.is_rd ? "rd_owner" : "wr_owner", e.is_rd ? rd_owner_out : wr_owner_out, e.owner);
    end
  endtask

  task automatic addrHandshake(input bit is_rd, input logic owner);
    if (is_rd) m_arready_in = 1'b1;
    else       m_awready_in = 1'b1;
    #1;
    checkOutput(is_rd ? "ar_ready_route" : "aw_ready_route",
                is_rd ? s_arready_out : s_awready_out, onehot(owner));
    tick();
    m_arready_in = 1'b0;
    m_awready_in = 1'b0;
  endtask

  task automatic finishRead(input logic owner, input int beats);
    for (int b = 0; b < beats; b++) begin
      m_rvalid_in = 1'b1;
      m_rlast_in  = (b == beats - 1);
      s_rready_in = 2'b11;
      #1;
      checkOutput("r_valid_route", s_rvalid_out, onehot(owner));
      checkOutput("r_ready_route", m_rready_out, 1'b1);
      tick();
    end
    m_rvalid_in = 1'b0;
    m_rlast_in  = 1'b0;
    #1;
    checkOutput("r_done_idle", m_rready_out, 1'b0);
    s_rready_in = 2'b00;
  endtask

  task automatic finishWrite(input logic owner, input int beats);
    for (int b = 0; b < beats; b++) begin
      s_wvalid_in[owner] = 1'b1;
      s_wlast_in[owner]  = (b == beats - 1);
      m_wready_in        = 1'b1;
      #1;
      checkOutput("w_ready_route", s_wready_out, onehot(owner));
      checkOutput("w_valid_fwd", m_wvalid_out, 1'b1);
      checkOutput("w_last_fwd", m_wlast_out, (b == beats - 1));
      tick();
    end
    s_wvalid_in[owner] = 1'b0;
    s_wlast_in[owner]  = 1'b0;
    m_wready_in        = 1'b0;
    m_bvalid_in        = 1'b1;
    s_bready_in        = 2'b11;
    #1;
    checkOutput("b_valid_route", s_bvalid_out, onehot(owner));
    checkOutput("b_ready_route", m_bready_out, 1'b1);
    tick();
    m_bvalid_in = 1'b0;
    #1;
    checkOutput("b_done_idle", m_bready_out, 1'b0);
    s_bready_in = 2'b00;
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.is_rd) begin
      s_araddr_in  = {v.a1, v.a0};
      s_arvalid_in = v.req;
    end else begin
      s_awaddr_in  = {v.a1, v.a0};
      s_awvalid_in = v.req;
    end
    sb.push_back('{v.is_rd, v.exp_owner, v.exp_addr});
    waitGrant(v.is_rd);
    addrHandshake(v.is_rd, v.exp_owner);
    s_arvalid_in = 2'b00;
    s_awvalid_in = 2'b00;
    if (v.is_rd) finishRead(v.exp_owner, 1);
    else         finishWrite(v.exp_owner, 1);
  endtask

  initial begin
    // Vectors assume both channels start from reset (last grant = requester 1).
    vecs[0] = '{1'b1, 2'b01, 32'h0000_1000, 32'h0000_0000, 1'b0, 32'h4000_1000};
    vecs[1] = '{1'b1, 2'b11, 32'h0000_0100, 32'h0000_0200, 1'b1, 32'h4000_0200};
    vecs[2] = '{1'b1, 2'b11, 32'h0000_0300, 32'h0000_0400, 1'b0, 32'h4000_0300};
    vecs[3] = '{1'b1, 2'b10, 32'h0000_0000, 32'hFFFF_FFFC, 1'b1, 32'h3FFF_FFFC};
    vecs[4] = '{1'b0, 2'b10, 32'h0000_0000, 32'hC000_0010, 1'b1, 32'h0000_0010};
    vecs[5] = '{1'b0, 2'b11, 32'h8000_0000, 32'h0000_0010, 1'b0, 32'hC000_0000};
    vecs[6] = '{1'b0, 2'b01, 32'hBFFF_FFFF, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF};
    vecs[7] = '{1'b0, 2'b11, 32'h0000_0020, 32'h0000_0030, 1'b1, 32'h4000_0030};

    doReset();

    // Single 4-beat read from requester 0.
    s_araddr_in  = {32'h0, 32'h0000_1000};
    s_arvalid_in = 2'b01;
    sb.push_back('{1'b1, 1'b0, 32'h4000_1000});
    waitGrant(1'b1);
    addrHandshake(1'b1, 1'b0);
    s_arvalid_in = 2'b00;
    finishRead(1'b0, 4);

    // Tie after reset: req0 first, req1 next even though req0 keeps requesting.
    doReset();
    s_araddr_in  = {32'h0000_0200, 32'h0000_0100};
    s_arvalid_in = 2'b11;
    sb.push_back('{1'b1, 1'b0, 32'h4000_0100});
    waitGrant(1'b1);
    addrHandshake(1'b1, 1'b0);
    finishRead(1'b0, 1);
    checkOutput("rr_idle_gap", m_arvalid_out, 1'b0);
    sb.push_back('{1'b1, 1'b1, 32'h4000_0200});
    waitGrant(1'b1);
    addrHandshake(1'b1, 1'b1);
    s_arvalid_in = 2'b00;
    finishRead(1'b1, 1);

    // 3-beat write from req1 with wraparound while req0 holds wvalid.
    s_awaddr_in  = {32'hC000_0010, 32'h0};
    s_awvalid_in = 2'b10;
    s_wvalid_in  = 2'b01;
    sb.push_back('{1'b0, 1'b1, 32'h0000_0010});
    waitGrant(1'b0);
    checkOutput("w_blocked_in_addr", s_wready_out, 2'b00);
    addrHandshake(1'b0, 1'b1);
    s_awvalid_in = 2'b00;
    finishWrite(1'b1, 3);
    s_wvalid_in = 2'b00;

    // Concurrent AW from req0 and AR from req1, completing independently.
    s_awaddr_in  = {32'h0, 32'h0000_0050};
    s_awvalid_in = 2'b01;
    s_araddr_in  = {32'h0000_0060, 32'h0};
    s_arvalid_in = 2'b10;
    tick();
    #1;
    checkOutput("concurrent_valids", {m_awvalid_out, m_arvalid_out}, 2'b11);
    checkOutput("concurrent_owners", {wr_owner_out, rd_owner_out}, 2'b01);
    checkOutput("concurrent_awaddr", m_awaddr_out, 32'h4000_0050);
    checkOutput("concurrent_araddr", m_araddr_out, 32'h4000_0060);
    m_arready_in = 1'b1;
    #1;
    checkOutput("concurrent_ar_ready", s_arready_out, 2'b10);
    checkOutput("concurrent_aw_held", s_awready_out, 2'b00);
    tick();
    m_arready_in = 1'b0;
    s_arvalid_in = 2'b00;
    finishRead(1'b1, 1);
    checkOutput("aw_still_pending", m_awvalid_out, 1'b1);
    addrHandshake(1'b0, 1'b0);
    s_awvalid_in = 2'b00;
    finishWrite(1'b0, 1);

    // Reset while the write channel sits in DATA.
    s_awaddr_in  = '0;
    s_awvalid_in = 2'b10;
    sb.push_back('{1'b0, 1'b1, 32'h4000_0000});
    waitGrant(1'b0);
    addrHandshake(1'b0, 1'b1);
    s_wvalid_in  = 2'b10;
    m_wready_in  = 1'b1;
    s_awaddr_in  = {32'h0000_0070, 32'h0000_0060};
    s_awvalid_in = 2'b11;
    m_awready_in = 1'b1;
    #1;
    checkOutput("data_wvalid", m_wvalid_out, 1'b1);
    checkOutput("data_wready", s_wready_out, 2'b10);
    checkOutput("data_no_new_aw", s_awready_out, 2'b00);
    rst_i = 1'b1;
    tick();
    #1;
    checkOutput("midrst_valids", {m_awvalid_out, m_wvalid_out, m_bready_out}, 3'b000);
    checkOutput("midrst_readies", {s_awready_out, s_wready_out}, 4'b0000);
    checkOutput("midrst_awaddr", m_awaddr_out, 32'h0);
    checkOutput("midrst_owner", wr_owner_out, 1'b0);
    rst_i        = 1'b0;
    m_awready_in = 1'b0;
    m_wready_in  = 1'b0;
    s_wvalid_in  = 2'b00;
    sb.push_back('{1'b0, 1'b0, 32'h4000_0060});
    waitGrant(1'b0);
    addrHandshake(1'b0, 1'b0);
    s_awvalid_in = 2'b00;
    finishWrite(1'b0, 1);

    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
    end

    checkOutput("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
